// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Programmable serial pattern detector. A pattern of 1..PAT_W bits is
//   loaded at run time and compared against the most recent valid serial
//   samples. Overlapping and non-overlapping detection are both supported.
//   A saturating counter records the number of hits.
//
// Ports
//   clk          sole clock; all state changes on its rising edge
//   rst          synchronous, active-high reset
//   din          serial data bit
//   din_valid    din is sampled only while this is 1
//   load         one-cycle strobe that captures pat_in / len_in
//   pat_in       pattern; pat_in[len-1] is the oldest bit, pat_in[0] the newest
//   len_in       pattern length, legal range 1..PAT_W
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   clr_cnt      clears match_count (wins over a same-cycle increment)
//   match        Moore output, high only in state HIT
//   match_count  saturating count of entries into HIT
//   cfg_err      sticky flag, set by an illegal load, cleared by a legal one
//   state_dbg    current FSM state encoding
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_UNCFG = 2'b00,
        ST_HUNT  = 2'b01,
        ST_HIT   = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
    localparam logic [PAT_W-1:0] ONE_W    = PAT_W'(1);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

    logic [LEN_W-1:0]   fill_inc;
    logic [PAT_W-1:0]   cmp_mask;
    logic               hit;

    // Mask of the low len bits. When len == PAT_W the shift wraps to zero and
    // the subtraction yields all ones, which is exactly the full-width mask.
    assign cmp_mask = (ONE_W << len_q) - ONE_W;

    // NOTE: every variable written here gets its hold value first, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        err_d    = err_q;
        hit      = 1'b0;
        fill_inc = (fill_q >= FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

        unique case (state_q)
            ST_UNCFG: state_d = ST_UNCFG;   // serial input ignored until loaded
            ST_HUNT, ST_HIT: begin
                if (din_valid) begin
                    hist_d = {hist_q[PAT_W-2:0], din};
                    // Hit is judged on the post-shift history and fill.
                    hit = (fill_inc >= len_q) && (((hist_d ^ pat_q) & cmp_mask) == '0);
                    if (hit) begin
                        state_d = ST_HIT;
                        fill_d  = overlap ? fill_inc : '0;
                    end else begin
                        state_d = ST_HUNT;
                        fill_d  = fill_inc;
                    end
                end else begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_UNCFG;    // illegal encoding recovers
        endcase

        // A load overrides the serial path; the same-cycle sample is dropped.
        if (load) begin
            hist_d = hist_q;
            if (len_in != '0 && len_in <= FILL_MAX) begin
                pat_d   = pat_in;
                len_d   = len_in;
                fill_d  = '0;
                err_d   = 1'b0;
                state_d = ST_HUNT;
            end else begin
                fill_d  = fill_q;
                err_d   = 1'b1;
                state_d = ST_UNCFG;
            end
        end

        // Count every cycle headed into HIT; the clear wins over the increment.
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (state_d == ST_HIT && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNCFG;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign match       = (state_q == ST_HIT);
    assign match_count = cnt_q;
    assign cfg_err     = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//   Directed, table-driven bench for seq_detect_param. A main instance
//   (PAT_W=8, CNT_W=8) is driven from a vector table; a second instance with
//   CNT_W=2 shares the inputs and is checked by a hand-written saturation
//   sequence. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, load, overlap, clr_cnt;
    logic [7:0] pat_in;
    logic [3:0] len_in;

    logic       match_a, cfg_err_a;
    logic [7:0] count_a;
    logic [1:0] state_a;
    logic       match_b, cfg_err_b;
    logic [1:0] count_b;
    logic [1:0] state_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
        .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_a), .match_count(count_a), .cfg_err(cfg_err_a),
        .state_dbg(state_a)
    );

    seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
        .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_b), .match_count(count_b), .cfg_err(cfg_err_b),
        .state_dbg(state_b)
    );

    typedef struct {
        string      tag;
        logic       rst, load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl, dv, din, clr;
        logic       em;
        logic [7:0] ec;
        logic       ee;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic r, ld, input logic [7:0] p,
                       input logic [3:0] l, input logic o, dv, d, c,
                       input logic em, input logic [7:0] ec, input logic ee,
                       input logic [1:0] es);
        vec_t v;
        v.tag = tag; v.rst = r; v.load = ld; v.pat = p; v.len = l;
        v.ovl = o; v.dv = dv; v.din = d; v.clr = c;
        v.em = em; v.ec = ec; v.ee = ee; v.es = es;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, ld, input logic [7:0] p, input logic [3:0] l,
                        input logic o, dv, d, c);
        rst = r; load = ld; pat_in = p; len_in = l;
        overlap = o; din_valid = dv; din = d; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   tag         rst ld pat    len  ovl dv din clr  m  cnt  err st
        add("reset",     1, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 8'd0, 0, 2'b00);
        add("uncfg_ign", 0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b00);
        add("uncfg_ign", 0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b00);
        // overlapping 101 on 1,0,1,0,1
        add("ld_101",    0, 1, 8'h05, 4'd3, 1, 0, 0, 0,   0, 8'd0, 0, 2'b01);
        add("ov_s1",     0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   0, 8'd0, 0, 2'b01);
        add("ov_s2",     0, 0, 8'h00, 4'd0, 1, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("ov_s3",     0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd1, 0, 2'b10);
        add("ov_s4",     0, 0, 8'h00, 4'd0, 1, 1, 0, 0,   0, 8'd1, 0, 2'b01);
        add("ov_s5",     0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd2, 0, 2'b10);
        add("ov_idle",   0, 0, 8'h00, 4'd0, 1, 0, 0, 0,   0, 8'd2, 0, 2'b01);
        add("clr",       0, 0, 8'h00, 4'd0, 1, 0, 0, 1,   0, 8'd0, 0, 2'b01);
        // non-overlapping 101 on 1,0,1,0,1
        add("ld_101_no", 0, 1, 8'h05, 4'd3, 0, 0, 0, 0,   0, 8'd0, 0, 2'b01);
        add("no_s1",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b01);
        add("no_s2",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("no_s3",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   1, 8'd1, 0, 2'b10);
        add("no_s4",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd1, 0, 2'b01);
        add("no_s5",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd1, 0, 2'b01);
        add("clr2",      0, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 8'd0, 0, 2'b01);
        // full-width A5 with a gap mid-stream
        add("ld_a5",     0, 1, 8'hA5, 4'd8, 0, 0, 0, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b7",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b6",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b5",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b4",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("a5_gap",    0, 0, 8'h00, 4'd0, 0, 0, 1, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b3",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b2",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b1",     0, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 8'd0, 0, 2'b01);
        add("a5_b0",     0, 0, 8'h00, 4'd0, 0, 1, 1, 0,   1, 8'd1, 0, 2'b10);
        add("a5_after",  0, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 8'd1, 0, 2'b01);
        // illegal loads: len 0 and len 9
        add("ld_len0",   0, 1, 8'h01, 4'd0, 1, 0, 0, 0,   0, 8'd1, 1, 2'b00);
        add("err_ign",   0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   0, 8'd1, 1, 2'b00);
        add("err_ign",   0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   0, 8'd1, 1, 2'b00);
        add("ld_ok",     0, 1, 8'h01, 4'd1, 1, 0, 0, 0,   0, 8'd1, 0, 2'b01);
        add("ld_len9",   0, 1, 8'h01, 4'd9, 1, 0, 0, 0,   0, 8'd1, 1, 2'b00);
        // legal load with a same-cycle valid 1: the sample is discarded
        add("ld_prio",   0, 1, 8'h01, 4'd1, 1, 1, 1, 0,   0, 8'd1, 0, 2'b01);
        add("len1_h1",   0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd2, 0, 2'b10);
        add("len1_h2",   0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd3, 0, 2'b10);
        add("len1_miss", 0, 0, 8'h00, 4'd0, 1, 1, 0, 0,   0, 8'd3, 0, 2'b01);
        add("clr_prio",  0, 0, 8'h00, 4'd0, 1, 1, 1, 1,   1, 8'd0, 0, 2'b10);
        add("hit_again", 0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd1, 0, 2'b10);
        // reset while in HIT, with other inputs active
        add("rst_hit",   1, 1, 8'h01, 4'd1, 1, 1, 1, 1,   0, 8'd0, 0, 2'b00);
        add("post_rst",  0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   0, 8'd0, 0, 2'b00);
        add("post_rst",  0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   0, 8'd0, 0, 2'b00);
        add("reload",    0, 1, 8'h01, 4'd1, 1, 0, 0, 0,   0, 8'd0, 0, 2'b01);
        add("reload_h",  0, 0, 8'h00, 4'd0, 1, 1, 1, 0,   1, 8'd1, 0, 2'b10);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].pat, vecs[i].len,
                 vecs[i].ovl, vecs[i].dv, vecs[i].din, vecs[i].clr);
            check({vecs[i].tag, ".match"}, 32'(match_a),   32'(vecs[i].em));
            check({vecs[i].tag, ".count"}, 32'(count_a),   32'(vecs[i].ec));
            check({vecs[i].tag, ".err"},   32'(cfg_err_a), 32'(vecs[i].ee));
            check({vecs[i].tag, ".state"}, 32'(state_a),   32'(vecs[i].es));
        end

        // Saturation on the 2-bit counter: len=1, pat=1, five valid ones,
        // clr_cnt asserted alongside the fifth.
        step(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.reset_cnt", 32'(count_b), 32'd0);
        step(1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.load_state", 32'(state_b), 32'b01);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, (k == 5));
            check($sformatf("sat.match%0d", k), 32'(match_b), 32'd1);
            check($sformatf("sat.cnt%0d", k), 32'(count_b),
                  (k == 5) ? 32'd0 : ((k >= 3) ? 32'd3 : 32'(k)));
        end
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.idle_match", 32'(match_b), 32'd0);
        check("sat.idle_state", 32'(state_b), 32'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, match-counter width.
REQ-003 Derived LEN_W = $clog2(PAT_W+1), width of length fields.
REQ-004 Timing: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  din is sampled only when this is 1.
REQ-009 load  input  1  one-cycle strobe that captures pat_in/len_in.
REQ-010 pat_in  input  PAT_W  pattern; pat_in[len-1] is the oldest bit, pat_in[0] the newest.
REQ-011 len_in  input  LEN_W  pattern length.
REQ-012 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-013 clr_cnt  input  1  clears match_count.
REQ-014 match  output  1  Moore output, high only in state HIT.
REQ-015 match_count  output  CNT_W  saturating count of HIT entries.
REQ-016 cfg_err  output  1  sticky error flag, set by an illegal load.
REQ-017 state_dbg  output  2  current FSM state encoding.

Function
REQ-018 States: UNCFG=2'b00, HUNT=2'b01, HIT=2'b10; code 2'b11 is illegal and SHALL go to UNCFG on the next cycle.
REQ-019 Internals: history shift register hist[PAT_W-1:0]; fill counter fill[LEN_W-1:0], which saturates at PAT_W.
REQ-020 Load is legal when 1 <= len_in <= PAT_W; a legal load captures pat/len, sets fill=0, clears cfg_err and next-state is HUNT.
REQ-021 An illegal load (len_in 0 or > PAT_W) sets cfg_err=1, next-state UNCFG, and leaves pat/len unchanged.
REQ-022 load has priority over din_valid in the same cycle; that din sample is discarded.
REQ-023 In UNCFG, din/din_valid are ignored; hist and fill do not change.
REQ-024 In HUNT or HIT with din_valid=1 and load=0:
- hist <= {hist[PAT_W-2:0], din};
- fill <= min(fill+1, PAT_W).
REQ-025 A hit is evaluated on the updated values: (fill_new >= len) and (hist_new[len-1:0] == pat[len-1:0]).
REQ-026 On a hit, next-state is HIT, so match rises in the cycle after the completing sample (latency 1).
REQ-027 On a hit with overlap=0, fill <= 0, so the next hit needs len fresh samples.
REQ-028 On a hit with overlap=1, fill keeps its updated value.
REQ-029 HIT with no valid sample, or a valid sample that is not a hit, SHALL go to HUNT; match is a one-cycle pulse per hit.
REQ-030 Back-to-back hits (overlap, len=1) keep the FSM in HIT; match stays high and count increments each cycle.
REQ-031 match_count increments on every cycle whose next-state is HIT, saturating at 2^CNT_W-1 with no wrap.
REQ-032 clr_cnt=1 sets match_count=0; clr_cnt has priority over a simultaneous increment, which is lost.
REQ-033 Bits of hist above len are ignored for comparison.

Reset
REQ-034 rst=1 forces, on the next edge:
- state UNCFG, match=0;
- match_count=0, cfg_err=0;
- hist=0, fill=0;
- pat=0, len=0.
REQ-035 rst overrides load, din_valid and clr_cnt, including when asserted mid-pattern or in HIT.
REQ-036 After reset, no match occurs until a legal load.

Verification
REQ-037 PAT_W=8; load pat=8'b101, len=3, overlap=1; valid din 1,0,1,0,1 -> match one cycle after the 3rd and 5th samples; match_count=2.
REQ-038 Same as REQ-037 with overlap=0 -> match only after the 3rd sample; match_count=1.
REQ-039 Load len=8, pat=8'hA5; serial 1010_0101 MSB first -> single match after the 8th sample; a gap cycle with din_valid=0 mid-stream SHALL NOT break detection.
REQ-040 Load len_in=0 -> cfg_err=1, state_dbg=00, no match on any stream; then a legal load -> cfg_err=0, state_dbg=01.
REQ-041 CNT_W=2, len=1, pat=1, overlap=1; five valid 1s -> match high for 5 cycles, match_count saturates at 3; clr_cnt during the last hit -> match_count=0.
REQ-042 rst asserted while in HIT -> next cycle match=0, match_count=0, state_dbg=00; the following stream produces no match until reload.
